memory_store_rmw: RTL

- Store-path counterpart of the load-side extender: takes byte, halfword or word store requests and writes them into a word-wide memory that has no byte enables.
- Sub-word stores are done as read-modify-write: read the word, merge the lane(s), write the word back. Word stores are written directly.
- Sits between the core's store stage and the data memory port. This block is the sole writer of that memory.

---
 rtl/memory_store_rmw.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/memory_store_rmw.sv
// memory_store_rmw: store path into a word-wide memory without byte enables.
// Word stores are written directly; byte/half stores do read-modify-write.
// Optional feature macro: MEMORY_STORE_MISALIGN_EN (misaligned word/half
// requests are aborted with err instead of being silently aligned).

`ifndef MEMORY_DATA_W
`define MEMORY_DATA_W 32
`endif
`ifndef MEMORY_WRAP_TYP_W
`define MEMORY_WRAP_TYP_W  3
`define MEMORY_WRAP_TYP_BS 3'd0
`define MEMORY_WRAP_TYP_BU 3'd1
`define MEMORY_WRAP_TYP_HS 3'd2
`define MEMORY_WRAP_TYP_HU 3'd3
`define MEMORY_WRAP_TYP_WS 3'd4
`endif

module memory_store_rmw #(
   parameter int unsigned DATA_W = `MEMORY_DATA_W,
   parameter int unsigned ADDR_W = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [`MEMORY_WRAP_TYP_W-1:0] req_typ,
   input  logic [ADDR_W-1:0]             req_addr,
   input  logic [DATA_W-1:0]             req_data,
   output logic [ADDR_W-3:0]             mem_addr,
   output logic                          mem_re,
   input  logic [DATA_W-1:0]             mem_rdata,
   output logic                          mem_we,
   output logic [DATA_W-1:0]             mem_wdata,
   output logic                          done,
   output logic                          err
);

   localparam int unsigned TYP_W = `MEMORY_WRAP_TYP_W;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_WRITE = 3'd3,
      ST_ERR   = 3'd4
   } state_e;

   state_e              state_q, state_d;
   logic [TYP_W-1:0]    typ_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   merged_c;
   logic [ADDR_W-1:0]   req_addr_c;
   logic                accept_c;
   logic                req_byte_c;
   logic                req_half_c;
   logic                req_sub_c;
   logic                misalign_c;
   logic                ready_q, ready_d;
   logic                re_q, re_d;
   logic                we_q, we_d;
   logic                done_q, done_d;

   assign accept_c  = (state_q == ST_IDLE) && req_valid;
   assign req_ready = ready_q;
   assign mem_re    = re_q;
   assign mem_we    = we_q;
   assign done      = done_q;
   assign mem_addr  = addr_q[ADDR_W-1:2];
   assign mem_wdata = wdata_q;

   // Decode the incoming request: access size, misalignment, aligned address
   always_comb begin
      req_byte_c = (req_typ == `MEMORY_WRAP_TYP_BS) || (req_typ == `MEMORY_WRAP_TYP_BU);
      req_half_c = (req_typ == `MEMORY_WRAP_TYP_HS) || (req_typ == `MEMORY_WRAP_TYP_HU);
      req_sub_c  = req_byte_c || req_half_c;
      req_addr_c = req_addr;
`ifdef MEMORY_STORE_MISALIGN_EN
      misalign_c = (!req_sub_c && (req_addr[1:0] != 2'b00)) || (req_half_c && req_addr[0]);
`else
      misalign_c = 1'b0;
      if (!req_sub_c) begin
         req_addr_c[1:0] = 2'b00;
      end else if (req_half_c) begin
         req_addr_c[0] = 1'b0;
      end
`endif
   end

   // Little-endian lane merge of the latched store data into the read word
   always_comb begin
      merged_c = mem_rdata;
      if ((typ_q == `MEMORY_WRAP_TYP_BS) || (typ_q == `MEMORY_WRAP_TYP_BU)) begin
         case (addr_q[1:0])
            2'd0:    merged_c[7:0]   = wdata_q[7:0];
            2'd1:    merged_c[15:8]  = wdata_q[7:0];
            2'd2:    merged_c[23:16] = wdata_q[7:0];
            default: merged_c[31:24] = wdata_q[7:0];
         endcase
      end else if ((typ_q == `MEMORY_WRAP_TYP_HS) || (typ_q == `MEMORY_WRAP_TYP_HU)) begin
         if (addr_q[1]) begin
            merged_c[31:16] = wdata_q[15:0];
         end else begin
            merged_c[15:0] = wdata_q[15:0];
         end
      end else begin
         merged_c = wdata_q;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (misalign_c) begin
                  state_d = ST_ERR;
               end else if (req_sub_c) begin
                  state_d = ST_READ;
               end else begin
                  state_d = ST_WRITE;
               end
            end
         end
         ST_READ:  state_d = ST_WAIT;
         ST_WAIT:  state_d = ST_WRITE;
         ST_WRITE: state_d = ST_IDLE;
         ST_ERR:   state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output decode from the upcoming state so the strobes come out of flops
   always_comb begin
      ready_d = (state_d == ST_IDLE);
      re_d    = (state_d == ST_READ);
      we_d    = (state_d == ST_WRITE);
      done_d  = (state_d == ST_WRITE) || (state_d == ST_ERR);
   end

   // Output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q <= 1'b1;
         re_q    <= 1'b0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         ready_q <= ready_d;
         re_q    <= re_d;
         we_q    <= we_d;
         done_q  <= done_d;
      end
   end

`ifdef MEMORY_STORE_MISALIGN_EN
   logic err_q, err_d;

   // Abort flag qualifying done
   always_comb begin
      err_d = (state_d == ST_ERR);
   end

   // Abort flag register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // Request latch; write data is replaced by the merged word once read data returns
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         typ_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (accept_c) begin
         typ_q   <= req_typ;
         addr_q  <= req_addr_c;
         wdata_q <= req_data;
      end else if (state_q == ST_WAIT) begin
         wdata_q <= merged_c;
      end
   end

endmodule
